// File: rtl/escritor_de_registradores.sv
// Write-side sequencer for the 32x32 register bank: buffers register-write
// results in a small FIFO, replays them as one-cycle bank write strobes,
// tracks pending destinations and sequences a bank-clear request.
// Optional feature macro: ESCRITOR_FORWARD_EN (rs lookup against queued writes).
module escritor_de_registradores #(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARGURA      = 32
) (
    input  logic               er_in_clk,
    input  logic               er_in_rst_n,
    input  logic               er_in_valid,
    output logic               er_out_ready,
    input  logic [4:0]         er_in_rd,
    input  logic [LARGURA-1:0] er_in_data,
    input  logic [7:0]         er_in_tipo,
    input  logic               er_in_limpar,
`ifdef ESCRITOR_FORWARD_EN
    input  logic [4:0]         er_in_rs,
    output logic               er_out_fwd_hit,
    output logic [LARGURA-1:0] er_out_fwd_data,
`endif
    output logic [2:0]         er_out_FSM,
    output logic [7:0]         er_out_FSM2,
    output logic [4:0]         er_out_rd,
    output logic [LARGURA-1:0] er_out_data,
    output logic [31:0]        er_out_pendente,
    output logic               er_out_vazio
);

    localparam int unsigned PTR_W = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int unsigned CNT_W = $clog2(PROFUNDIDADE + 1);

    typedef struct packed {
        logic [7:0]         tipo;
        logic [4:0]         rd;
        logic [LARGURA-1:0] data;
    } entrada_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESCREVE = 2'd1,
        LIMPA   = 2'd2
    } estado_t;

    entrada_t         mem [PROFUNDIDADE];
    entrada_t         pres;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    estado_t          state;
    estado_t          nxt_state;
    logic             limpar_pend;
    logic             push;
    logic             pop;
    logic             cheio;
    logic             fifo_vazia;
    logic             tipo_ok;

    // Occupancy flags and accept filter
    always_comb begin
        cheio        = (count == CNT_W'(PROFUNDIDADE));
        fifo_vazia   = (count == '0);
        er_out_ready = !cheio && (state != LIMPA);
        tipo_ok      = (er_in_tipo == 8'h01) || (er_in_tipo == 8'h02) ||
                       (er_in_tipo == 8'h03) || (er_in_tipo == 8'h06);
        push         = er_in_valid && er_out_ready && (er_in_rd != 5'd0) && tipo_ok;
    end

    // Next-state and pop decision
    always_comb begin
        nxt_state = state;
        pop       = 1'b0;
        case (state)
            OCIOSO: begin
                if (limpar_pend && fifo_vazia) begin
                    nxt_state = LIMPA;
                end else if (!fifo_vazia) begin
                    pop       = 1'b1;
                    nxt_state = ESCREVE;
                end
            end
            ESCREVE: begin
                if (!fifo_vazia && !limpar_pend) begin
                    pop = 1'b1;
                end else begin
                    nxt_state = OCIOSO;
                end
            end
            LIMPA:   nxt_state = OCIOSO;
            default: nxt_state = OCIOSO;
        endcase
    end

    // State, pointers, occupancy, clear flag and presented entry
    always_ff @(posedge er_in_clk or negedge er_in_rst_n) begin
        if (!er_in_rst_n) begin
            state       <= OCIOSO;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            limpar_pend <= 1'b0;
            pres        <= '0;
        end else begin
            state <= nxt_state;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count       <= count + CNT_W'(push) - CNT_W'(pop);
            limpar_pend <= (state == LIMPA) ? 1'b0 : (limpar_pend || er_in_limpar);
            pres        <= pop ? mem[rd_ptr] : '0;
        end
    end

    // FIFO storage; contents are meaningless outside the occupied window
    always_ff @(posedge er_in_clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tipo: er_in_tipo, rd: er_in_rd, data: er_in_data};
        end
    end

    // Bank-facing outputs decoded from the registered state and entry
    always_comb begin
        er_out_FSM   = 3'b111;
        er_out_FSM2  = pres.tipo;
        er_out_rd    = pres.rd;
        er_out_data  = pres.data;
        er_out_vazio = fifo_vazia && (state != ESCREVE);
        case (state)
            ESCREVE: er_out_FSM = 3'b110;
            LIMPA:   er_out_FSM = 3'b000;
            default: er_out_FSM = 3'b111;
        endcase
    end

    // Pending-destination scoreboard over queued and presented entries
    always_comb begin
        logic [PTR_W-1:0] idx_p;
        er_out_pendente = '0;
        idx_p           = '0;
        if (state == ESCREVE) begin
            er_out_pendente[pres.rd] = 1'b1;
        end
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            idx_p = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                er_out_pendente[mem[idx_p].rd] = 1'b1;
            end
        end
    end

`ifdef ESCRITOR_FORWARD_EN
    // Newest-value lookup: presented entry first, then queue oldest to newest
    always_comb begin
        logic [PTR_W-1:0] idx_f;
        er_out_fwd_hit  = 1'b0;
        er_out_fwd_data = '0;
        idx_f           = '0;
        if (er_in_rs != 5'd0) begin
            if ((state == ESCREVE) && (pres.rd == er_in_rs)) begin
                er_out_fwd_hit  = 1'b1;
                er_out_fwd_data = pres.data;
            end
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                idx_f = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (mem[idx_f].rd == er_in_rs)) begin
                    er_out_fwd_hit  = 1'b1;
                    er_out_fwd_data = mem[idx_f].data;
                end
            end
        end
    end
`endif

endmodule
